// File: rtl/int_mult_arbiter_if.sv
// Request/issue/result bundle shared by requesters, the multiplier arbiter and IntMultUnit.
// Latency: none (wires only).
// Backpressure: I_Stall from the multiplier side; O_Gnt tells a requester its op was taken.
// Ports (slave = arbiter view):
//   in : I_Req, I_OpA, I_OpB, I_Opc, I_Flush, I_Stall, I_MulV, I_MulD
//   out: O_Gnt, O_MulEn, O_MulA, O_MulB, O_MulOpc, O_RsltV, O_RsltD, O_Busy, O_Err
interface int_mult_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_OPC  = 4
);
  logic [NUM_REQ-1:0]            I_Req;
  logic [NUM_REQ*WIDTH_DATA-1:0] I_OpA;
  logic [NUM_REQ*WIDTH_DATA-1:0] I_OpB;
  logic [NUM_REQ*WIDTH_OPC-1:0]  I_Opc;
  logic [NUM_REQ-1:0]            O_Gnt;
  logic                          I_Flush;
  logic                          I_Stall;
  logic                          O_MulEn;
  logic [WIDTH_DATA-1:0]         O_MulA;
  logic [WIDTH_DATA-1:0]         O_MulB;
  logic [WIDTH_OPC-1:0]          O_MulOpc;
  logic                          I_MulV;
  logic [WIDTH_DATA-1:0]         I_MulD;
  logic [NUM_REQ-1:0]            O_RsltV;
  logic [WIDTH_DATA-1:0]         O_RsltD;
  logic                          O_Busy;
  logic                          O_Err;

  // Requester/ALU side: drives requests, control and multiplier results.
  modport master (
    output I_Req, I_OpA, I_OpB, I_Opc, I_Flush, I_Stall, I_MulV, I_MulD,
    input  O_Gnt, O_MulEn, O_MulA, O_MulB, O_MulOpc, O_RsltV, O_RsltD, O_Busy, O_Err
  );

  // Arbiter side.
  modport slave (
    input  I_Req, I_OpA, I_OpB, I_Opc, I_Flush, I_Stall, I_MulV, I_MulD,
    output O_Gnt, O_MulEn, O_MulA, O_MulB, O_MulOpc, O_RsltV, O_RsltD, O_Busy, O_Err
  );
endinterface

// File: rtl/int_mult_arbiter.sv
// Round-robin scheduler sharing one pipelined IntMultUnit among NUM_REQ requesters.
// Latency: grant is combinational; result routed the same cycle as I_MulV (LATENCY after grant).
// Backpressure: I_Stall freezes the tag pipe and blocks grants; in-flight ops capped at LATENCY.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : requests/operands in, one-hot grant out, multiplier issue out,
//                  multiplier result in, one-hot routed result out, O_Busy, sticky O_Err
module int_mult_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_DATA = 32,
  parameter int LATENCY    = 2,
  parameter int WIDTH_OPC  = 4
) (
  input  logic              clock,
  input  logic              reset,
  int_mult_arbiter_if.slave bus
);
  localparam int WIDTH_ID  = $clog2(NUM_REQ);
  localparam int WIDTH_CNT = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic                v;
    logic [WIDTH_ID-1:0] id;
  } tag_t;

  state_t               state;
  state_t               stateNext;
  logic [WIDTH_ID-1:0]  rrPtr;
  tag_t                 tagPipe [LATENCY];
  tag_t                 tagOut;
  logic [WIDTH_CNT-1:0] inFlight;
  logic [WIDTH_CNT-1:0] inFlightNext;
  logic                 errFlag;

  logic                 anyReq;
  logic                 routed;
  logic                 atCap;
  logic                 canIssue;
  logic                 issue;
  logic                 found;
  logic [WIDTH_ID-1:0]  winId;

  assign tagOut = tagPipe[LATENCY-1];
  assign anyReq = |bus.I_Req;
  assign routed = bus.I_MulV & tagOut.v;

  // A result leaving this cycle frees a slot, so a full pipe may still accept one op.
  assign atCap    = (inFlight == WIDTH_CNT'(LATENCY)) && !routed;
  assign canIssue = (state == RUN) && !reset && !bus.I_Flush && !bus.I_Stall && !atCap;
  assign issue    = canIssue && found;

  // Round-robin scan starting at rrPtr, wrapping at NUM_REQ (need not be a power of two).
  always_comb begin
    logic [WIDTH_ID:0] sum;
    sum   = '0;
    found = 1'b0;
    winId = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rrPtr} + (WIDTH_ID + 1)'(i);
      if (sum >= (WIDTH_ID + 1)'(NUM_REQ)) begin
        sum = sum - (WIDTH_ID + 1)'(NUM_REQ);
      end
      if (!found && bus.I_Req[sum[WIDTH_ID-1:0]]) begin
        found = 1'b1;
        winId = sum[WIDTH_ID-1:0];
      end
    end
  end

  // Grant and issue mux; operands are forced to zero when nothing is issued.
  always_comb begin
    bus.O_Gnt    = '0;
    bus.O_MulEn  = 1'b0;
    bus.O_MulA   = '0;
    bus.O_MulB   = '0;
    bus.O_MulOpc = '0;
    if (issue) begin
      bus.O_Gnt[winId] = 1'b1;
      bus.O_MulEn      = 1'b1;
      bus.O_MulA       = bus.I_OpA[int'(winId)*WIDTH_DATA +: WIDTH_DATA];
      bus.O_MulB       = bus.I_OpB[int'(winId)*WIDTH_DATA +: WIDTH_DATA];
      bus.O_MulOpc     = bus.I_Opc[int'(winId)*WIDTH_OPC +: WIDTH_OPC];
    end
  end

  // Result routing to the requester whose tag reaches the end of the pipe.
  always_comb begin
    bus.O_RsltV = '0;
    bus.O_RsltD = '0;
    if (routed) begin
      bus.O_RsltV[tagOut.id] = 1'b1;
      bus.O_RsltD            = bus.I_MulD;
    end
  end

  assign bus.O_Busy = (inFlight != '0) || (state != IDLE);
  assign bus.O_Err  = errFlag;

  always_comb begin
    inFlightNext = inFlight;
    if (issue && !routed) begin
      inFlightNext = inFlight + 1'b1;
    end else if (!issue && routed) begin
      inFlightNext = inFlight - 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (anyReq && !bus.I_Flush) stateNext = RUN;
      end
      RUN: begin
        if (bus.I_Flush) begin
          stateNext = DRAIN;
        end else if (!anyReq && inFlight == '0) begin
          stateNext = IDLE;
        end
      end
      DRAIN: begin
        // Leave as soon as the last in-flight result has been routed.
        if (inFlightNext == '0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr    <= '0;
      inFlight <= '0;
      errFlag  <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        tagPipe[i] <= '0;
      end
    end else begin
      inFlight <= inFlightNext;
      // A result with no matching tag is dropped; remember that it happened.
      if (bus.I_MulV && !tagOut.v) begin
        errFlag <= 1'b1;
      end
      if (issue) begin
        rrPtr <= (winId == WIDTH_ID'(NUM_REQ - 1)) ? '0 : winId + 1'b1;
      end
      // The tag pipe moves in lockstep with the multiplier pipeline.
      if (!bus.I_Stall) begin
        tagPipe[0] <= '{v: issue, id: (issue ? winId : '0)};
        for (int i = 1; i < LATENCY; i++) begin
          tagPipe[i] <= tagPipe[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_int_mult_arbiter.sv
// Self-checking bench for int_mult_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model and a small stallable multiplier model.
module tb_int_mult_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int WIDTH_DATA = 32;
  localparam int LATENCY    = 2;
  localparam int WIDTH_OPC  = 4;
  localparam int M_IDLE     = 0;
  localparam int M_RUN      = 1;
  localparam int M_DRAIN    = 2;

  logic clock = 1'b1;
  logic reset;

  int nChecks = 0;
  int nErrors = 0;
  int cyc     = 0;

  int_mult_arbiter_if #(
    .NUM_REQ(NUM_REQ), .WIDTH_DATA(WIDTH_DATA), .WIDTH_OPC(WIDTH_OPC)
  ) bus ();

  int_mult_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH_DATA(WIDTH_DATA), .LATENCY(LATENCY), .WIDTH_OPC(WIDTH_OPC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference model: outstanding ops in issue order, plus the scheduler's visible rules.
  typedef struct {
    int                    id;
    logic [WIDTH_DATA-1:0] data;
    int                    cyc;
    int                    stalls;
  } op_t;

  op_t sb[$];
  int  mMode;
  int  mPtr;
  bit  mErr;
  int  stallCnt;
  bit  spurious;

  // Behavioural multiplier: fixed-latency product pipe that freezes on I_Stall.
  logic                  mulV [LATENCY];
  logic [WIDTH_DATA-1:0] mulD [LATENCY];

  // Outputs sampled each cycle.
  int                    sCyc;
  logic [NUM_REQ-1:0]    sGnt, sRsltV;
  logic [WIDTH_DATA-1:0] sRsltD, sMulA, sMulB;
  logic [WIDTH_OPC-1:0]  sMulOpc;
  logic                  sMulEn, sBusy, sErr;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic setOps(input int i, input logic [WIDTH_DATA-1:0] a,
                        input logic [WIDTH_DATA-1:0] b, input logic [WIDTH_OPC-1:0] o);
    bus.I_OpA[i*WIDTH_DATA +: WIDTH_DATA] = a;
    bus.I_OpB[i*WIDTH_DATA +: WIDTH_DATA] = b;
    bus.I_Opc[i*WIDTH_OPC +: WIDTH_OPC]   = o;
  endtask

  task automatic clearModel();
    sb.delete();
    mMode = M_IDLE;
    mPtr  = 0;
    mErr  = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      mulV[i] = 1'b0;
      mulD[i] = '0;
    end
  endtask

  // One clock: drive multiplier result, sample at negedge, check, advance models, edge.
  task automatic runCycle();
    logic [NUM_REQ-1:0]    req, expGnt, expRV;
    logic [WIDTH_DATA-1:0] expA, expB;
    logic [WIDTH_OPC-1:0]  expOpc;
    bit                    routedNow, spur, grantOk, expBusy;
    int                    k, j, sizeBefore;
    op_t                   op;

    bus.I_MulV = (mulV[LATENCY-1] && !bus.I_Stall && !reset) || spurious;
    bus.I_MulD = mulD[LATENCY-1];
    @(negedge clock);
    sCyc    = cyc;
    sGnt    = bus.O_Gnt;
    sMulEn  = bus.O_MulEn;
    sMulA   = bus.O_MulA;
    sMulB   = bus.O_MulB;
    sMulOpc = bus.O_MulOpc;
    sRsltV  = bus.O_RsltV;
    sRsltD  = bus.O_RsltD;
    sBusy   = bus.O_Busy;
    sErr    = bus.O_Err;

    req        = bus.I_Req;
    routedNow  = bus.I_MulV && (sb.size() != 0);
    spur       = bus.I_MulV && (sb.size() == 0);
    grantOk    = (mMode == M_RUN) && !reset && !bus.I_Flush && !bus.I_Stall &&
                 !((sb.size() == LATENCY) && !routedNow);
    k = -1;
    if (grantOk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        j = (mPtr + i) % NUM_REQ;
        if (k < 0 && req[j]) k = j;
      end
    end
    expGnt = '0;
    expA   = '0;
    expB   = '0;
    expOpc = '0;
    if (k >= 0) begin
      expGnt[k] = 1'b1;
      expA      = bus.I_OpA[k*WIDTH_DATA +: WIDTH_DATA];
      expB      = bus.I_OpB[k*WIDTH_DATA +: WIDTH_DATA];
      expOpc    = bus.I_Opc[k*WIDTH_OPC +: WIDTH_OPC];
    end
    expRV = '0;
    if (routedNow) expRV[sb[0].id] = 1'b1;
    expBusy = (sb.size() != 0) || (mMode != M_IDLE);

    checkEq("gnt", sGnt, expGnt);
    checkEq("mulEn", sMulEn, k >= 0);
    checkEq("mulA", sMulA, expA);
    checkEq("mulB", sMulB, expB);
    checkEq("mulOpc", sMulOpc, expOpc);
    checkEq("rsltV", sRsltV, expRV);
    if (routedNow) begin
      checkEq("rsltD", sRsltD, sb[0].data);
      checkEq("latency", (cyc - sb[0].cyc) - (stallCnt - sb[0].stalls), LATENCY);
    end
    checkEq("busy", sBusy, expBusy);
    checkEq("err", sErr, mErr);

    if (reset) begin
      clearModel();
    end else begin
      sizeBefore = sb.size();
      if (routedNow) void'(sb.pop_front());
      if (spur) mErr = 1'b1;
      if (k >= 0) begin
        op.id     = k;
        op.data   = expA * expB;
        op.cyc    = cyc;
        op.stalls = stallCnt;
        sb.push_back(op);
        mPtr = (k + 1) % NUM_REQ;
      end
      case (mMode)
        M_IDLE:  if (req != 0 && !bus.I_Flush) mMode = M_RUN;
        M_RUN: begin
          if (bus.I_Flush) mMode = M_DRAIN;
          else if (req == 0 && sizeBefore == 0) mMode = M_IDLE;
        end
        M_DRAIN: if (sb.size() == 0) mMode = M_IDLE;
        default: mMode = M_IDLE;
      endcase
      if (bus.I_Stall) begin
        stallCnt++;
      end else begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          mulV[i] = mulV[i-1];
          mulD[i] = mulD[i-1];
        end
        mulV[0] = sMulEn;
        mulD[0] = sMulA * sMulB;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int                 t, f, idle, nG;
    int                 r [2];
    logic [NUM_REQ-1:0] e, acc;

    reset       = 1'b1;
    spurious    = 1'b0;
    stallCnt    = 0;
    bus.I_Req   = '0;
    bus.I_OpA   = '0;
    bus.I_OpB   = '0;
    bus.I_Opc   = '0;
    bus.I_Flush = 1'b0;
    bus.I_Stall = 1'b0;
    bus.I_MulV  = 1'b0;
    bus.I_MulD  = '0;
    clearModel();

    // Reset state: all outputs zero once the reset edge has been taken.
    runCycle();
    runCycle();
    checkEq("reset_gnt", sGnt, 0);
    checkEq("reset_mulEn", sMulEn, 0);
    checkEq("reset_rsltV", sRsltV, 0);
    checkEq("reset_busy", sBusy, 0);
    checkEq("reset_err", sErr, 0);
    reset = 1'b0;

    // Single requester 1: 3*5 returns to requester 1 LATENCY cycles after grant.
    setOps(1, 32'd3, 32'd5, 4'h2);
    bus.I_Req = 4'b0010;
    t = -100;
    for (int n = 0; n < 5 && t < 0; n++) begin
      runCycle();
      if (sGnt != 0) t = sCyc;
    end
    checkEq("single_gnt", sGnt, 4'b0010);
    bus.I_Req = '0;
    f = -100;
    for (int n = 0; n < 6 && f < 0; n++) begin
      runCycle();
      if (sRsltV != 0) f = sCyc;
    end
    checkEq("single_rsltV", sRsltV, 4'b0010);
    checkEq("single_rsltD", sRsltD, 15);
    checkEq("single_lat", f - t, LATENCY);

    // All requesters continuously from reset: strict rotation, one grant per cycle.
    for (int i = 0; i < NUM_REQ; i++) setOps(i, $urandom(), $urandom(), 4'(i));
    bus.I_Req = 4'b1111;
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    for (int n = 0; n < 9; n++) begin
      runCycle();
      e = '0;
      if (n > 0) e[(n - 1) % NUM_REQ] = 1'b1;
      checkEq("rr_seq", sGnt, e);
    end
    bus.I_Req = '0;
    for (int n = 0; n < 4; n++) runCycle();

    // Stall for 3 cycles with two ops in flight: results slip by exactly 3 cycles.
    bus.I_Req = 4'b0011;
    t = -100;
    for (int n = 0; n < 6 && t < 0; n++) begin
      runCycle();
      if (sGnt != 0) t = sCyc;
    end
    checkEq("stall_gnt1", sGnt, 4'b0001);
    runCycle();
    checkEq("stall_gnt2", sGnt, 4'b0010);
    bus.I_Stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      runCycle();
      checkEq("stall_nognt", sGnt, 0);
    end
    bus.I_Stall = 1'b0;
    bus.I_Req   = '0;
    r[0] = -100;
    r[1] = -100;
    nG   = 0;
    for (int n = 0; n < 8; n++) begin
      runCycle();
      if (sRsltV != 0 && nG < 2) begin
        r[nG] = sCyc;
        nG++;
      end
    end
    checkEq("stall_r1", r[0] - t, LATENCY + 3);
    checkEq("stall_r2", r[1] - t, LATENCY + 4);

    // Flush mid-stream: no grant in the flush cycle, idle LATENCY cycles later.
    bus.I_Req = 4'b1111;
    for (int n = 0; n < 6; n++) runCycle();
    bus.I_Flush = 1'b1;
    runCycle();
    checkEq("flush_gnt", sGnt, 0);
    f = sCyc;
    bus.I_Flush = 1'b0;
    bus.I_Req   = '0;
    idle = -100;
    for (int n = 0; n < 8; n++) begin
      runCycle();
      if (!sBusy && idle < 0) idle = sCyc;
    end
    checkEq("flush_idle", idle - f, LATENCY);

    // Reset with two ops in flight: everything quiet afterwards.
    bus.I_Req = 4'b0011;
    nG = 0;
    for (int n = 0; n < 6 && nG < 2; n++) begin
      runCycle();
      if (sGnt != 0) nG++;
    end
    checkEq("rst_inflight", nG, 2);
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    runCycle();
    checkEq("rst_gnt", sGnt, 0);
    checkEq("rst_mulEn", sMulEn, 0);
    checkEq("rst_rsltV", sRsltV, 0);
    checkEq("rst_busy", sBusy, 0);
    checkEq("rst_err", sErr, 0);
    bus.I_Req = '0;
    acc = '0;
    for (int n = 0; n < 6; n++) begin
      runCycle();
      acc = acc | sRsltV;
    end
    checkEq("rst_no_rslt", acc, 0);

    // Spurious multiplier result with nothing in flight.
    spurious = 1'b1;
    runCycle();
    checkEq("spur_rsltV", sRsltV, 0);
    spurious = 1'b0;
    runCycle();
    checkEq("spur_err", sErr, 1);

    // Randomized traffic with stalls and flushes.
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bus.I_Req = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        setOps(i, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      end
      bus.I_Stall = ($urandom_range(0, 7) == 0);
      bus.I_Flush = ($urandom_range(0, 15) == 0);
      runCycle();
    end
    bus.I_Req   = '0;
    bus.I_Stall = 1'b0;
    bus.I_Flush = 1'b0;
    for (int n = 0; n < 8; n++) runCycle();
    checkEq("final_idle", sBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
